// File: rtl/rdma_rd_req_responder_pkg.sv
// Shared types and constants for the RDMA read-request responder path:
// request descriptor, bus widths and the byte-remainder to tkeep helper.
package rdma_rd_req_responder_pkg;

   localparam int LEN_BITS       = 28;
   localparam int AXI_NET_BITS   = 512;
   localparam int RSP_BEAT_BYTES = AXI_NET_BITS / 8;
   localparam int OFS_BITS       = $clog2(RSP_BEAT_BYTES);
   localparam int BEAT_BITS      = LEN_BITS - OFS_BITS + 1;

   typedef struct packed {
      logic [3:0]          opcode;
      logic [5:0]          pid;
      logic [47:0]         vaddr;
      logic [LEN_BITS-1:0] len;
   } req_t;

   // A zero remainder means the final beat is completely filled.
   function automatic logic [RSP_BEAT_BYTES-1:0] len2keep(input logic [OFS_BITS-1:0] rem);
      logic [RSP_BEAT_BYTES-1:0] keep;
      for (int i = 0; i < RSP_BEAT_BYTES; i++) begin
         keep[i] = (rem == '0) || (i < int'(rem));
      end
      return keep;
   endfunction

   function automatic logic [BEAT_BITS-1:0] len2beats(input logic [LEN_BITS-1:0] len);
      return BEAT_BITS'(len[LEN_BITS-1:OFS_BITS]) + BEAT_BITS'(|len[OFS_BITS-1:0]);
   endfunction

endpackage

// File: rtl/rdma_rd_req_responder_queue.sv
// Request FIFO with full/empty flags; head is read combinationally so the
// framer can use the length in the same cycle it pops.
module rdma_req_queue #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic [W-1:0] mem_q [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/rdma_rd_req_responder.sv
// Frames an unframed 512-bit source stream into one response packet per
// queued RDMA READ request, using only the request length for boundaries.
//
// state     | meaning
// ST_IDLE   | waiting for a queued (or arriving) request
// ST_LOAD   | pop head, compute beat count and final-beat remainder
// ST_STREAM | move source beats into the output register until the last
module rdma_rd_req_responder
   import rdma_rd_req_responder_pkg::*;
#(
   parameter int REQ_DEPTH = 8,
   parameter int CNT_BITS  = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_rdma_rd_req_valid,
   output logic                      s_rdma_rd_req_ready,
   input  req_t                      s_rdma_rd_req_data,
   input  logic                      s_axis_src_tvalid,
   output logic                      s_axis_src_tready,
   input  logic [AXI_NET_BITS-1:0]   s_axis_src_tdata,
   input  logic [RSP_BEAT_BYTES-1:0] s_axis_src_tkeep,
   input  logic                      s_axis_src_tlast,
   output logic                      m_axis_rdma_rd_req_tvalid,
   input  logic                      m_axis_rdma_rd_req_tready,
   output logic [AXI_NET_BITS-1:0]   m_axis_rdma_rd_req_tdata,
   output logic [RSP_BEAT_BYTES-1:0] m_axis_rdma_rd_req_tkeep,
   output logic                      m_axis_rdma_rd_req_tlast,
   output logic [CNT_BITS-1:0]       cnt_done,
   output logic                      busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [BEAT_BITS-1:0]      beat_cnt_q, beat_cnt_d;
   logic [OFS_BITS-1:0]       rem_q, rem_d;
   logic [CNT_BITS-1:0]       cnt_q, cnt_d;
   logic                      rdy_q;
   logic                      out_vld_q;
   logic [AXI_NET_BITS-1:0]   out_data_q;
   logic [RSP_BEAT_BYTES-1:0] out_keep_q;
   logic                      out_last_q;

   logic                q_full, q_empty, push, pop, src_hs, last_beat;
   logic [LEN_BITS-1:0] head_len;

   // Only the length is consumed; the remaining fields and source framing are dropped.
   logic unused_ign;
   assign unused_ign = ^{s_rdma_rd_req_data.opcode, s_rdma_rd_req_data.pid,
                         s_rdma_rd_req_data.vaddr, s_axis_src_tkeep, s_axis_src_tlast};

   assign s_rdma_rd_req_ready = rdy_q && !q_full;
   assign push                = s_rdma_rd_req_valid && s_rdma_rd_req_ready;
   assign pop                 = (state_q == ST_LOAD);
   assign s_axis_src_tready   = (state_q == ST_STREAM) && (!out_vld_q || m_axis_rdma_rd_req_tready);
   assign src_hs              = s_axis_src_tvalid && s_axis_src_tready;
   assign last_beat           = (beat_cnt_q == BEAT_BITS'(1));

   rdma_req_queue #(
      .DEPTH (REQ_DEPTH),
      .W     (LEN_BITS)
   ) u_req_queue (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .push_i      (push),
      .push_data_i (s_rdma_rd_req_data.len),
      .pop_i       (pop),
      .head_o      (head_len),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      case (state_q)
         // An arriving request counts as present so LOAD follows the push directly.
         ST_IDLE: if (!q_empty || push) state_d = ST_LOAD;
         ST_LOAD: begin
            if (head_len == '0) begin
               cnt_d   = cnt_q + CNT_BITS'(1);
               state_d = ST_IDLE;
            end else begin
               beat_cnt_d = len2beats(head_len);
               rem_d      = head_len[OFS_BITS-1:0];
               state_d    = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (src_hs) begin
               beat_cnt_d = beat_cnt_q - BEAT_BITS'(1);
               if (last_beat) begin
                  cnt_d   = cnt_q + CNT_BITS'(1);
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         rdy_q      <= 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_keep_q <= '0;
         out_last_q <= 1'b0;
      end else if (src_hs) begin
         out_vld_q  <= 1'b1;
         out_data_q <= s_axis_src_tdata;
         out_keep_q <= last_beat ? len2keep(rem_q) : '1;
         out_last_q <= last_beat;
      end else if (m_axis_rdma_rd_req_tready) begin
         out_vld_q  <= 1'b0;
      end
   end

   assign m_axis_rdma_rd_req_tvalid = out_vld_q;
   assign m_axis_rdma_rd_req_tdata  = out_data_q;
   assign m_axis_rdma_rd_req_tkeep  = out_keep_q;
   assign m_axis_rdma_rd_req_tlast  = out_last_q;
   assign cnt_done                  = cnt_q;
   assign busy                      = !q_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_rdma_rd_req_responder.sv
// Randomized bench for rdma_rd_req_responder: a length-driven packet model
// predicts data order, tkeep and tlast of every output beat.
module tb_rdma_rd_req_responder;
   import rdma_rd_req_responder_pkg::*;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;
   always #5 aclk = ~aclk;

   logic                      s_rdma_rd_req_valid = 1'b0;
   logic                      s_rdma_rd_req_ready;
   req_t                      req_data = '0;
   logic                      s_axis_src_tvalid = 1'b0;
   logic                      s_axis_src_tready;
   logic [AXI_NET_BITS-1:0]   s_axis_src_tdata = '0;
   logic [RSP_BEAT_BYTES-1:0] s_axis_src_tkeep = '0;
   logic                      s_axis_src_tlast = 1'b0;
   logic                      m_tvalid;
   logic                      m_tready = 1'b0;
   logic [AXI_NET_BITS-1:0]   m_tdata;
   logic [RSP_BEAT_BYTES-1:0] m_tkeep;
   logic                      m_tlast;
   logic [31:0]               cnt_done;
   logic                      busy;

   rdma_rd_req_responder #(.REQ_DEPTH(8), .CNT_BITS(32)) dut (
      .aclk                      (aclk),
      .aresetn                   (aresetn),
      .s_rdma_rd_req_valid       (s_rdma_rd_req_valid),
      .s_rdma_rd_req_ready       (s_rdma_rd_req_ready),
      .s_rdma_rd_req_data        (req_data),
      .s_axis_src_tvalid         (s_axis_src_tvalid),
      .s_axis_src_tready         (s_axis_src_tready),
      .s_axis_src_tdata          (s_axis_src_tdata),
      .s_axis_src_tkeep          (s_axis_src_tkeep),
      .s_axis_src_tlast          (s_axis_src_tlast),
      .m_axis_rdma_rd_req_tvalid (m_tvalid),
      .m_axis_rdma_rd_req_tready (m_tready),
      .m_axis_rdma_rd_req_tdata  (m_tdata),
      .m_axis_rdma_rd_req_tkeep  (m_tkeep),
      .m_axis_rdma_rd_req_tlast  (m_tlast),
      .cnt_done                  (cnt_done),
      .busy                      (busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: accepted lengths and accepted source beats, in order.
   int unsigned   len_q[$];
   logic [511:0]  src_q[$];
   int            cur_len = 0, cur_nb = 0, cur_idx = 0;
   int            n_req = 0, exp_beats = 0, got_beats = 0;
   bit            src_hs_last = 0, prev_stall = 0;
   logic [511:0]  prev_data;
   logic [63:0]   prev_keep;
   logic          prev_last;
   bit            src_en = 0;
   int            src_pct = 100, snk_pct = 100;

   function automatic logic [63:0] exp_keep(input int len, input bit last);
      int r;
      if (!last) return {64{1'b1}};
      r = len % 64;
      return (r == 0) ? {64{1'b1}} : ((64'd1 << r) - 64'd1);
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic reset_model();
      len_q.delete();
      src_q.delete();
      cur_len = 0; cur_nb = 0; cur_idx = 0;
      n_req = 0; exp_beats = 0; got_beats = 0;
   endtask

   task automatic score_beat();
      bit last;
      if (cur_idx >= cur_nb) begin
         while (len_q.size() > 0 && len_q[0] == 0) void'(len_q.pop_front());
         if (len_q.size() == 0) begin
            chk("sb_req_avail", len_q.size(), 1);
            return;
         end
         cur_len = len_q.pop_front();
         cur_nb  = (cur_len + 63) / 64;
         cur_idx = 0;
      end
      got_beats++;
      if (src_q.size() == 0) chk("sb_src_avail", src_q.size(), 1);
      else chk("sb_data", m_tdata, src_q.pop_front());
      last = (cur_idx == cur_nb - 1);
      chk("sb_last", m_tlast, last);
      chk("sb_keep", m_tkeep, exp_keep(cur_len, last));
      cur_idx++;
   endtask

   // Monitor samples mid-cycle; a handshake seen here commits at the next posedge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         src_hs_last = 0;
         prev_stall  = 0;
      end else begin
         src_hs_last = s_axis_src_tvalid && s_axis_src_tready;
         if (src_hs_last) src_q.push_back(s_axis_src_tdata);
         if (s_rdma_rd_req_valid && s_rdma_rd_req_ready) begin
            len_q.push_back(int'(req_data.len));
            n_req++;
            exp_beats += (int'(req_data.len) + 63) / 64;
         end
         if (prev_stall) begin
            chk("hold_vld", m_tvalid, 1'b1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_keep", m_tkeep, prev_keep);
            chk("hold_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) score_beat();
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_keep  = m_tkeep;
         prev_last  = m_tlast;
      end
   end

   always @(posedge aclk) begin
      #1;
      if (!aresetn) begin
         s_axis_src_tvalid = 1'b0;
      end else if (!(s_axis_src_tvalid && !src_hs_last && src_en)) begin
         s_axis_src_tvalid = src_en && ($urandom_range(99) < src_pct);
         s_axis_src_tdata  = rnd512();
         s_axis_src_tkeep  = {$urandom, $urandom};
         s_axis_src_tlast  = 1'($urandom_range(1));
      end
   end

   always @(posedge aclk) begin
      #1;
      m_tready = ($urandom_range(99) < snk_pct);
   end

   task automatic send_req(input int len);
      bit ok = 0;
      req_data        = '0;
      req_data.len    = LEN_BITS'(len);
      req_data.vaddr  = 48'({$urandom, $urandom});
      req_data.opcode = 4'($urandom);
      s_rdma_rd_req_valid = 1'b1;
      for (int i = 0; i < 6000 && !ok; i++) begin
         @(negedge aclk);
         if (s_rdma_rd_req_ready) ok = 1;
      end
      @(posedge aclk); #1;
      s_rdma_rd_req_valid = 1'b0;
      chk("req_accept", ok, 1'b1);
   endtask

   task automatic check_quiet(input string tag);
      bit done = 0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge aclk);
         if (!busy && !m_tvalid) done = 1;
      end
      chk({tag, "_idle"}, done, 1'b1);
      chk({tag, "_cnt_done"}, cnt_done, n_req);
      chk({tag, "_beats"}, got_beats, exp_beats);
      chk({tag, "_src_left"}, src_q.size(), 0);
      @(posedge aclk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 aresetn = 1'b0;
      #2;
      chk("rst_req_ready", s_rdma_rd_req_ready, 1'b0);
      chk("rst_src_tready", s_axis_src_tready, 1'b0);
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_tlast", m_tlast, 1'b0);
      chk("rst_tkeep", m_tkeep, 64'd0);
      chk("rst_tdata", m_tdata, 512'd0);
      chk("rst_cnt_done", cnt_done, 32'd0);
      chk("rst_busy", busy, 1'b0);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      chk("ready_before_edge", s_rdma_rd_req_ready, 1'b0);
      @(posedge aclk); #1;
      chk("ready_after_edge", s_rdma_rd_req_ready, 1'b1);

      // Single full beat: latency and framing.
      src_en = 1; src_pct = 100; snk_pct = 100;
      repeat (2) @(posedge aclk); #1;
      send_req(64);
      @(negedge aclk); chk("lat_c1_vld", m_tvalid, 1'b0);
      @(negedge aclk); chk("lat_c2_vld", m_tvalid, 1'b0);
      @(negedge aclk); chk("lat_c3_vld", m_tvalid, 1'b1);
      chk("lat_c3_last", m_tlast, 1'b1);
      chk("lat_c3_keep", m_tkeep, {64{1'b1}});
      @(posedge aclk); #1;
      check_quiet("len64");

      send_req(130);
      check_quiet("len130");
      send_req(0);
      check_quiet("len0");
      send_req(1);
      check_quiet("len1");

      // Framer parked in STREAM with no source data; queue must fill at 8.
      src_en = 0;
      repeat (2) @(posedge aclk); #1;
      send_req(640);
      repeat (3) @(posedge aclk); #1;
      for (int k = 0; k < 8; k++) send_req(64 * (k + 1));
      req_data.len = LEN_BITS'(100);
      s_rdma_rd_req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge aclk);
         chk("full_ready_low", s_rdma_rd_req_ready, 1'b0);
      end
      @(posedge aclk); #1;
      src_en = 1;
      send_req(100);
      check_quiet("fill");

      // Random lengths under random backpressure.
      src_pct = 80; snk_pct = 50;
      for (int k = 0; k < 100; k++) send_req($urandom_range(4096, 1));
      check_quiet("random");
      src_pct = 100; snk_pct = 100;

      // Reset in the middle of a long packet.
      send_req(640);
      repeat (5) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      chk("midrst_tvalid", m_tvalid, 1'b0);
      chk("midrst_cnt_done", cnt_done, 32'd0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_src_tready", s_axis_src_tready, 1'b0);
      reset_model();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      send_req(64);
      check_quiet("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
